// File: rtl/ram_rw_sp.sv
// Single-port synchronous RAM with registered read data, read-valid strobe and a
// hardware clear sequencer that zeroes every word after reset and on request.
module ram_rw_sp #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_req,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_din,
  input  logic                  i_clr,
  output logic [DATA_WIDTH-1:0] o_dout,
  output logic                  o_dout_valid,
  output logic                  o_busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {StClear, StIdle} state_e;

  state_e                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_clr_ptr, w_clr_ptr_nxt;
  logic [DATA_WIDTH-1:0] r_dout, w_dout_nxt;
  logic                  r_dout_valid, w_dout_valid_nxt;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_mem_we;
  logic [ADDR_WIDTH-1:0] w_mem_addr;
  logic [DATA_WIDTH-1:0] w_mem_wdata;

  always_comb begin
    w_state_nxt      = r_state;
    w_clr_ptr_nxt    = r_clr_ptr;
    w_dout_nxt       = r_dout;
    w_dout_valid_nxt = 1'b0;
    w_mem_we         = 1'b0;
    w_mem_addr       = i_addr;
    w_mem_wdata      = i_din;
    unique case (r_state)
      StClear: begin
        // Client requests are ignored entirely while sweeping.
        w_mem_we    = 1'b1;
        w_mem_addr  = r_clr_ptr;
        w_mem_wdata = '0;
        if (r_clr_ptr == {ADDR_WIDTH{1'b1}}) begin
          w_state_nxt   = StIdle;
          w_clr_ptr_nxt = '0;
        end else begin
          w_clr_ptr_nxt = r_clr_ptr + 1'b1;
        end
      end
      StIdle: begin
        if (i_clr) begin
          w_state_nxt   = StClear;
          w_clr_ptr_nxt = '0;
        end else if (i_req && i_we) begin
          w_mem_we = 1'b1;
        end else if (i_req) begin
          w_dout_nxt       = r_mem[i_addr];
          w_dout_valid_nxt = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= StClear;
      r_clr_ptr    <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_clr_ptr    <= w_clr_ptr_nxt;
      r_dout       <= w_dout_nxt;
      r_dout_valid <= w_dout_valid_nxt;
    end
  end

  // Storage has no reset; only the clear sequencer zeroes it.
  always_ff @(posedge i_clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  assign o_dout       = r_dout;
  assign o_dout_valid = r_dout_valid;
  assign o_busy       = (r_state == StClear);

endmodule

// File: tb/tb_ram_rw_sp.sv
// Directed plus randomized bench for ram_rw_sp: three instances (4/8, 2/4, 6/32)
// checked against an array-based memory model kept here.
module tb_ram_rw_sp;

  logic        clk;
  logic        rst   [3];
  logic        req   [3];
  logic        we    [3];
  logic        clr   [3];
  logic [5:0]  addr  [3];
  logic [31:0] din   [3];

  logic [7:0]  dout0;
  logic [3:0]  dout1;
  logic [31:0] dout2;
  logic        dv0, dv1, dv2;
  logic        busy0, busy1, busy2;

  int aws [3] = '{4, 2, 6};
  int dws [3] = '{8, 4, 32};

  logic [31:0] mdl   [3][64];
  logic [31:0] mdout [3];

  int checks   = 0;
  int failures = 0;

  ram_rw_sp #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) u_dut0 (
    .i_clk(clk), .i_reset(rst[0]), .i_req(req[0]), .i_we(we[0]), .i_addr(addr[0][3:0]),
    .i_din(din[0][7:0]), .i_clr(clr[0]), .o_dout(dout0), .o_dout_valid(dv0), .o_busy(busy0)
  );

  ram_rw_sp #(.ADDR_WIDTH(2), .DATA_WIDTH(4)) u_dut1 (
    .i_clk(clk), .i_reset(rst[1]), .i_req(req[1]), .i_we(we[1]), .i_addr(addr[1][1:0]),
    .i_din(din[1][3:0]), .i_clr(clr[1]), .o_dout(dout1), .o_dout_valid(dv1), .o_busy(busy1)
  );

  ram_rw_sp #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) u_dut2 (
    .i_clk(clk), .i_reset(rst[2]), .i_req(req[2]), .i_we(we[2]), .i_addr(addr[2]),
    .i_din(din[2]), .i_clr(clr[2]), .o_dout(dout2), .o_dout_valid(dv2), .o_busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] f_dout(input int k);
    case (k)
      0:       return {24'b0, dout0};
      1:       return {28'b0, dout1};
      default: return dout2;
    endcase
  endfunction

  function automatic logic [31:0] f_dv(input int k);
    case (k)
      0:       return {31'b0, dv0};
      1:       return {31'b0, dv1};
      default: return {31'b0, dv2};
    endcase
  endfunction

  function automatic logic [31:0] f_busy(input int k);
    case (k)
      0:       return {31'b0, busy0};
      1:       return {31'b0, busy1};
      default: return {31'b0, busy2};
    endcase
  endfunction

  function automatic logic [31:0] f_mask(input int k);
    if (dws[k] == 32) return 32'hFFFF_FFFF;
    return (32'h1 << dws[k]) - 32'h1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k, input logic r, input logic w, input logic [5:0] a,
                       input logic [31:0] d, input logic c);
    req[k]  = r;
    we[k]   = w;
    addr[k] = a;
    din[k]  = d;
    clr[k]  = c;
  endtask

  task automatic idle(input int k);
    drive(k, 1'b0, 1'b0, 6'd0, 32'd0, 1'b0);
  endtask

  task automatic zero_model(input int k);
    for (int a = 0; a < 64; a++) mdl[k][a] = 32'd0;
  endtask

  task automatic do_write(input int k, input logic [5:0] a, input logic [31:0] d);
    drive(k, 1'b1, 1'b1, a, d & f_mask(k), 1'b0);
    step();
    idle(k);
    mdl[k][a] = d & f_mask(k);
    chk("write_dout_hold", f_dout(k), mdout[k]);
    chk("write_no_valid", f_dv(k), 32'd0);
  endtask

  task automatic do_read(input int k, input logic [5:0] a);
    drive(k, 1'b1, 1'b0, a, 32'd0, 1'b0);
    step();
    idle(k);
    mdout[k] = mdl[k][a];
    chk("read_data", f_dout(k), mdout[k]);
    chk("read_valid", f_dv(k), 32'd1);
  endtask

  // Counts cycles with busy high, optionally hammering writes that must be dropped.
  task automatic measure_clear(input int k, input bit with_writes, output int cnt);
    cnt = 0;
    while (f_busy(k) == 32'd1 && cnt < 200) begin
      if (with_writes) drive(k, 1'b1, 1'b1, 6'(cnt), 32'hFFFF_FFEE & f_mask(k), 1'b0);
      cnt++;
      step();
      if (with_writes) chk("clear_dout_hold", f_dout(k), mdout[k]);
    end
    idle(k);
    zero_model(k);
  endtask

  initial begin
    int cnt [3];
    int c;
    int depth;
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1;
      idle(k);
      mdout[k] = 32'd0;
      zero_model(k);
    end
    #2;
    for (int k = 0; k < 3; k++) begin
      chk("reset_busy", f_busy(k), 32'd1);
      chk("reset_dout", f_dout(k), 32'd0);
      chk("reset_valid", f_dv(k), 32'd0);
    end
    #1;
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b0;
      cnt[k] = 0;
    end

    // Power-up clear length for all three geometries at once.
    for (int i = 0; i < 70; i++) begin
      for (int k = 0; k < 3; k++) if (f_busy(k) == 32'd1) cnt[k]++;
      step();
    end
    chk("powerup_clear_len0", 32'(cnt[0]), 32'd16);
    chk("powerup_clear_len1", 32'(cnt[1]), 32'd4);
    chk("powerup_clear_len2", 32'(cnt[2]), 32'd64);

    for (int a = 0; a < 16; a++) do_read(0, 6'(a));

    // Write / read-back, back-to-back reads.
    do_write(0, 6'd3, 32'hA5);
    do_write(0, 6'd15, 32'h3C);
    do_read(0, 6'd3);
    do_read(0, 6'd15);
    do_read(0, 6'd0);

    // Hold behaviour.
    do_read(0, 6'd3);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_dout", f_dout(0), 32'hA5);
      chk("hold_valid", f_dv(0), 32'd0);
    end
    do_write(0, 6'd3, 32'h11);
    do_read(0, 6'd3);

    // Clear request wins over a same-cycle read; writes during busy are dropped.
    for (int a = 0; a < 16; a++) do_write(0, 6'(a), 32'hFF);
    drive(0, 1'b1, 1'b0, 6'd7, 32'd0, 1'b1);
    step();
    idle(0);
    chk("clr_prio_valid", f_dv(0), 32'd0);
    chk("clr_prio_dout", f_dout(0), mdout[0]);
    measure_clear(0, 1'b1, c);
    chk("clr_len", 32'(c), 32'd16);
    for (int a = 0; a < 16; a++) do_read(0, 6'(a));

    // Reset in the middle of a clear sweep.
    do_write(0, 6'd9, 32'h5A);
    do_read(0, 6'd9);
    drive(0, 1'b0, 1'b0, 6'd0, 32'd0, 1'b1);
    step();
    idle(0);
    for (int i = 0; i < 5; i++) step();
    chk("midclr_busy", f_busy(0), 32'd1);
    chk("midclr_dout", f_dout(0), 32'h5A);
    #2;
    rst[0] = 1'b1;
    #1;
    chk("async_rst_busy", f_busy(0), 32'd1);
    chk("async_rst_dout", f_dout(0), 32'd0);
    chk("async_rst_valid", f_dv(0), 32'd0);
    mdout[0] = 32'd0;
    #1;
    rst[0] = 1'b0;
    measure_clear(0, 1'b0, c);
    chk("rst_clear_len", 32'(c), 32'd16);
    for (int a = 0; a < 16; a++) do_read(0, 6'(a));

    // Clear length on the other geometries.
    for (int k = 1; k < 3; k++) begin
      drive(k, 1'b0, 1'b0, 6'd0, 32'd0, 1'b1);
      step();
      idle(k);
      measure_clear(k, 1'b0, c);
      chk("sweep_clr_len", 32'(c), 32'(1 << aws[k]));
    end

    // Walking ones over every address.
    for (int k = 0; k < 3; k++) begin
      depth = 1 << aws[k];
      for (int a = 0; a < depth; a++) do_write(k, 6'(a), 32'h1 << (a % dws[k]));
      for (int a = 0; a < depth; a++) do_read(k, 6'(a));
    end

    // Randomized reads and writes against the model.
    for (int k = 0; k < 3; k++) begin
      depth = 1 << aws[k];
      for (int i = 0; i < 150; i++) begin
        if ($urandom_range(0, 1) == 1) do_write(k, 6'($urandom_range(0, depth - 1)), $urandom);
        else do_read(k, 6'($urandom_range(0, depth - 1)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_rw_sp.md
# ram_rw_sp

Parametrised single-port synchronous RAM with registered read data, a read-valid strobe, and a hardware clear sequencer. The sequencer zeroes every word one address per cycle, both after reset and on request. It is the generalised successor of the fixed 4x4 R/W RAM and serves as the scratch/data memory for small datapath blocks. Clients issue one request per cycle and must respect `busy`.

## Interface
- `ADDR_WIDTH`, default 4: address width in bits; depth is DEPTH = 2**ADDR_WIDTH words.
- `DATA_WIDTH`, default 8: word width in bits.
- `clk`  in  1: single clock; all state updates on its rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `req`  in  1: access request, sampled at the rising edge.
- `we`  in  1: with `req`, 1 = write and 0 = read.
- `addr`  in  ADDR_WIDTH: word address.
- `din`  in  DATA_WIDTH: write data.
- `clr`  in  1: request a full-memory clear. Pulse or level; sampled only in IDLE.
- `dout`  out  DATA_WIDTH: registered read data; holds its value between reads.
- `dout_valid`  out  1: one-cycle strobe meaning `dout` was updated by a read this cycle.
- `busy`  out  1: clear sequence in progress; requests are ignored while high.

## Operation
- Storage is a DEPTH x DATA_WIDTH array with no per-word reset. Contents are zeroed only by the clear sequencer.
- The FSM has two states, CLEAR and IDLE. An internal pointer `clr_ptr` is ADDR_WIDTH bits wide.
- Reset assertion, asynchronous, forces the following immediately:
  - state = CLEAR, `clr_ptr` = 0;
  - `busy` = 1, `dout` = 0, `dout_valid` = 0.
- CLEAR state, on each edge:
  - writes mem[`clr_ptr`] <= 0 and increments `clr_ptr`;
  - on the edge that writes address DEPTH-1, moves to IDLE, resets `clr_ptr` to 0 and drops `busy` to 0;
  - ignores `req`, `we` and `clr` (no restart, no queueing); `dout` holds and `dout_valid` = 0.
- IDLE state, on each edge, in priority order:
  1. `clr`=1: move to CLEAR with `clr_ptr`=0 and `busy`=1. Any `req` in the same cycle is dropped. `dout_valid`=0.
  2. `req`=1, `we`=1: mem[`addr`] <= `din`. `dout` unchanged, `dout_valid`=0.
  3. `req`=1, `we`=0: `dout` <= mem[`addr`], `dout_valid`=1.
  4. Otherwise: `dout` holds, `dout_valid`=0.
- Reading an address written on an earlier edge returns the new data. A write on edge N followed by a read on edge N+1 returns the value written at N.
- Reset asserted mid-clear or mid-access aborts the operation and restarts the full clear. A write in flight at the reset edge is not guaranteed to land.
- `addr` is always in range (all 2**ADDR_WIDTH codes are valid), so no bounds check is needed.

## Timing
- Read latency is 1 cycle. With `req`=1, `we`=0 sampled at edge N, `dout` and `dout_valid`=1 are valid after edge N and until edge N+1.
- Back-to-back reads produce `dout_valid` high continuously, with new data every cycle.
- Write latency is 1 cycle; the data is visible to a read issued on the next edge.
- Clear duration is exactly DEPTH edges:
  - after reset release, `busy` is high through DEPTH rising edges, then falls;
  - after `clr` is sampled in IDLE, `busy` rises after that edge and stays high for DEPTH further edges;
  - the first accepted request is on the edge after `busy` is seen low.
- Client rule: sample `busy` before driving `req`. There is no backpressure beyond `busy`, and dropped requests are not reported.

## Test plan
- **Power-up clear** (defaults): release reset → `busy`=1 for exactly 16 edges, then 0. Reading addresses 0..15 returns 0x00 each, with `dout_valid` high one cycle per read.
- **Write/read-back**: write 0xA5 to addr 3 and 0x3C to addr 15, then read 3, 15, 0 back-to-back → `dout` = 0xA5, 0x3C, 0x00 on consecutive cycles, with `dout_valid` held high for 3 cycles.
- **Hold behaviour**: read addr 3 (0xA5), idle 5 cycles, then write 0x11 to addr 3 → `dout` stays 0xA5 and `dout_valid`=0 throughout. The next read of addr 3 returns 0x11.
- **Clear request and priority**: fill all words with 0xFF, then assert `clr` and a read of addr 7 on the same edge → no `dout_valid`, `busy` high 16 cycles. Writes issued during `busy` are dropped, and every word reads back 0x00 afterwards.
- **Reset mid-clear**: assert `clr`, then assert reset asynchronously (between edges) after 5 clear cycles → `busy`=1, `dout`=0 and `dout_valid`=0 immediately. After release, `busy` lasts a full 16 edges and all words read 0x00.
- **Parameter sweep**: ADDR_WIDTH=2, DATA_WIDTH=4 and ADDR_WIDTH=6, DATA_WIDTH=32 → clear lasts 4 and 64 edges respectively. A walking-ones write/read-back over all addresses matches.
